demux_channel_buffer: RTL and testbench
=======================================

Name: demux_channel_buffer

Overview:
- Sits directly downstream of the 4-bit 1-to-2 demux.
- Captures the word on the demux output currently selected by the demux select. Queues it in a per-channel FIFO (channel 1 = out1, channel 2 = out2).
- Presents each channel to its consumer through an independent valid/ready handshake.
- Also checks demux integrity: the unselected output must read zero.

Parameters:
- DATA_W, 4, width of each channel word (matches the demux word width)
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_ch1  input  DATA_W  demux out1
- in_ch2  input  DATA_W  demux out2
- in_sel  input  1  same select that drives the demux; 0 selects out1 / channel 1, 1 selects out2 / channel 2
- in_valid  input  1  upstream word valid this cycle
- in_ready  output  1  selected channel can accept a word
- ch1_data  output  DATA_W  channel 1 head word
- ch1_valid  output  1  channel 1 non-empty
- ch1_ready  input  1  channel 1 consumer accepts
- ch2_data  output  DATA_W  channel 2 head word
- ch2_valid  output  1  channel 2 non-empty
- ch2_ready  input  1  channel 2 consumer accepts
- ch1_count  output  $clog2(DEPTH)+1  channel 1 occupancy
- ch2_count  output  $clog2(DEPTH)+1  channel 2 occupancy
- integrity_err  output  1  sticky demux-integrity error

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: all pointers and counts are 0. ch1_valid = ch2_valid = 0, ch1_data = ch2_data = 0, integrity_err = 0. in_ready is then 1, since both FIFOs are empty.
- Reset applied mid-operation discards all queued words on the next edge. No partial state survives.
- in_ready is combinational: in_sel ? !full2 : !full1. It does not depend on in_valid.
- Push: on in_valid && in_ready, the word in_sel ? in_ch2 : in_ch1 is written to the selected FIFO tail. The unselected FIFO is untouched.
- in_valid with the selected FIFO full: no write, nothing dropped. Upstream holds the word until in_ready rises.
- Pop: on chN_valid && chN_ready, the head advances. The two channels pop independently and may pop in the same cycle.
- chN_valid = (countN != 0). chN_data = head entry when non-empty, otherwise 0 (registered/array-read, no X).
- Latency: a pushed word appears on chN_data/chN_valid the cycle after the push edge. There is no same-cycle bypass.
- Push and pop on the same channel in the same cycle:
  - Not full: both occur and count is unchanged.
  - Full: the push is blocked because in_ready = 0, even though a pop frees a slot in that cycle. There is no push-on-pop-when-full.
- Empty FIFO: a pop request (chN_ready with chN_valid = 0) is ignored, and pointers do not move.
- Pointers wrap modulo DEPTH. Count saturates structurally at DEPTH via in_ready.
- Integrity check: on any cycle with in_valid = 1, if the unselected input (in_sel ? in_ch1 : in_ch2) is nonzero, integrity_err is set the next edge.
  - The check applies whether or not the push is accepted.
  - The flag is sticky and cleared only by reset.
  - The offending word is still pushed normally.

Decomposition:
- Shared package holds:
  - DATA_W and DEPTH defaults
  - select encoding constants SEL_CH1 = 1'b0, SEL_CH2 = 1'b1
  - count width, derived as $clog2(DEPTH)+1
- One natural sub-module: channel_fifo. It is a single-clock synchronous FIFO with push, pop, data_in, data_out, full, empty and count, and is instantiated twice.
- The top level holds:
  - in_ready and select muxing
  - push/pop qualification
  - the integrity checker

Test Plan:
- Reset then idle: assert reset 2 cycles -> in_ready=1, ch1_valid=ch2_valid=0, data=0, counts=0, integrity_err=0.
- Routing: in_sel=0, in_ch1=4'hA, in_ch2=0, in_valid 1 cycle -> next cycle ch1_valid=1, ch1_data=A, ch1_count=1, ch2_valid=0. Then in_sel=1, in_ch2=4'h5 -> ch2_data=5.
- Full/back-pressure: ch1_ready=0, push 3, 7, 9 on channel 1 -> 3 and 7 accepted, ch1_count=2, in_ready=0 while in_sel=0 (9 held). Switch in_sel=1 -> in_ready=1. Then ch1_ready=1 -> pops 3, then 7, in order.
- Simultaneous push/pop: channel 2 holding 1 word, push 4'hC with ch2_ready=1 -> count stays 1, head becomes C next cycle. Wrap exercised over 6 consecutive words with data order preserved.
- Integrity: in_valid=1, in_sel=0, in_ch1=2, in_ch2=4'h1 -> integrity_err=1 next cycle and stays 1 after clean traffic. Channel 1 still receives 2. Reset clears the flag.
- Reset mid-operation: both FIFOs full, assert reset 1 cycle -> counts=0, valids=0 the next cycle, and a subsequent push behaves as from empty.

Source files
------------

// File: rtl/demux_channel_buffer_pkg.sv
// Shared defaults and encodings for the demux channel buffer.
package demux_channel_buffer_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned DEPTH_DEF  = 2;
    localparam int unsigned CNT_W_DEF  = $clog2(DEPTH_DEF) + 1;

    localparam logic SEL_CH1 = 1'b0;
    localparam logic SEL_CH2 = 1'b1;

endpackage

// File: rtl/demux_channel_buffer_channel_fifo.sv
// Single-clock synchronous FIFO; head word reads as zero when empty.
module demux_channel_buffer_channel_fifo #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Guard against pushing when full or popping when empty
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
        if (pop_ok)  rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
        case ({push_ok, pop_ok})
            2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
            2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reads are masked while empty
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/demux_channel_buffer.sv
// Buffers the selected demux output into per-channel FIFOs and flags
// any nonzero word on the unselected demux output.
module demux_channel_buffer
    import demux_channel_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      in_ch1,
    input  logic [DATA_W-1:0]      in_ch2,
    input  logic                   in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      ch1_data,
    output logic                   ch1_valid,
    input  logic                   ch1_ready,
    output logic [DATA_W-1:0]      ch2_data,
    output logic                   ch2_valid,
    input  logic                   ch2_ready,
    output logic [$clog2(DEPTH):0] ch1_count,
    output logic [$clog2(DEPTH):0] ch2_count,
    output logic                   integrity_err
);

    logic              full1, full2;
    logic              empty1, empty2;
    logic              push1, push2;
    logic              pop1, pop2;
    logic [DATA_W-1:0] unsel_word;
    logic              err_q, err_d;

    assign in_ready = (in_sel == SEL_CH2) ? !full2 : !full1;

    assign push1 = in_valid && in_ready && (in_sel == SEL_CH1);
    assign push2 = in_valid && in_ready && (in_sel == SEL_CH2);
    assign pop1  = ch1_ready && !empty1;
    assign pop2  = ch2_ready && !empty2;

    assign ch1_valid = !empty1;
    assign ch2_valid = !empty2;

    demux_channel_buffer_channel_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ch1_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push1),
        .pop_i   (pop1),
        .data_i  (in_ch1),
        .data_o  (ch1_data),
        .full_o  (full1),
        .empty_o (empty1),
        .count_o (ch1_count)
    );

    demux_channel_buffer_channel_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ch2_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push2),
        .pop_i   (pop2),
        .data_i  (in_ch2),
        .data_o  (ch2_data),
        .full_o  (full2),
        .empty_o (empty2),
        .count_o (ch2_count)
    );

    // Integrity: the demux must drive zero on the output it did not select
    assign unsel_word = (in_sel == SEL_CH2) ? in_ch1 : in_ch2;

    always_comb begin
        err_d = err_q;
        if (in_valid && (unsel_word != '0)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign integrity_err = err_q;

endmodule

// File: tb/tb_demux_channel_buffer.sv
// Directed plus random bench for demux_channel_buffer with a queue scoreboard.
module tb_demux_channel_buffer;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] in_ch1, in_ch2;
    logic              in_sel, in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] ch1_data, ch2_data;
    logic              ch1_valid, ch2_valid;
    logic              ch1_ready, ch2_ready;
    logic [1:0]        ch1_count, ch2_count;
    logic              integrity_err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] q1 [$];
    logic [DATA_W-1:0] q2 [$];
    logic              err_m;

    always #5 clk = ~clk;

    demux_channel_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_ch1        (in_ch1),
        .in_ch2        (in_ch2),
        .in_sel        (in_sel),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ch1_data      (ch1_data),
        .ch1_valid     (ch1_valid),
        .ch1_ready     (ch1_ready),
        .ch2_data      (ch2_data),
        .ch2_valid     (ch2_valid),
        .ch2_ready     (ch2_ready),
        .ch1_count     (ch1_count),
        .ch2_count     (ch2_count),
        .integrity_err (integrity_err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check handshake/pops before the edge, state after it
    task automatic cycle();
        logic [DATA_W-1:0] e;
        logic              exp_rdy;
        @(negedge clk);
        exp_rdy = in_sel ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
        check("in_ready", 8'(in_ready), 8'(exp_rdy));
        if (reset) begin
            q1.delete();
            q2.delete();
            err_m = 1'b0;
        end else begin
            if (in_valid && ((in_sel ? in_ch1 : in_ch2) != '0)) err_m = 1'b1;
            if (ch1_ready && q1.size() > 0) begin
                e = q1.pop_front();
                check("ch1_pop_data", 8'(ch1_data), 8'(e));
            end
            if (ch2_ready && q2.size() > 0) begin
                e = q2.pop_front();
                check("ch2_pop_data", 8'(ch2_data), 8'(e));
            end
            if (in_valid && exp_rdy) begin
                if (in_sel) q2.push_back(in_ch2);
                else        q1.push_back(in_ch1);
            end
        end
        @(posedge clk);
        #1;
        check("ch1_valid", 8'(ch1_valid), 8'(q1.size() != 0));
        check("ch1_data",  8'(ch1_data),  (q1.size() != 0) ? 8'(q1[0]) : 8'h00);
        check("ch1_count", 8'(ch1_count), 8'(q1.size()));
        check("ch2_valid", 8'(ch2_valid), 8'(q2.size() != 0));
        check("ch2_data",  8'(ch2_data),  (q2.size() != 0) ? 8'(q2[0]) : 8'h00);
        check("ch2_count", 8'(ch2_count), 8'(q2.size()));
        check("integrity_err", 8'(integrity_err), 8'(err_m));
    endtask

    task automatic drive(input logic v, input logic s, input logic [DATA_W-1:0] d1,
                         input logic [DATA_W-1:0] d2, input logic r1, input logic r2);
        in_valid  = v;
        in_sel    = s;
        in_ch1    = d1;
        in_ch2    = d2;
        ch1_ready = r1;
        ch2_ready = r2;
        cycle();
    endtask

    initial begin
        err_m = 1'b0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // Routing to each channel
        drive(1, 0, 4'hA, 4'h0, 0, 0);
        drive(1, 1, 4'h0, 4'h5, 0, 0);
        drive(0, 0, 0, 0, 1, 1);

        // Back-pressure on channel 1: 9 is held while full
        drive(1, 0, 4'h3, 4'h0, 0, 0);
        drive(1, 0, 4'h7, 4'h0, 0, 0);
        drive(1, 0, 4'h9, 4'h0, 0, 0);
        drive(1, 0, 4'h9, 4'h0, 0, 0);
        drive(0, 1, 4'h0, 4'h0, 0, 0);
        drive(0, 1, 4'h0, 4'h0, 1, 0);
        drive(0, 1, 4'h0, 4'h0, 1, 0);

        // Simultaneous push/pop on channel 2
        drive(1, 1, 4'h0, 4'h1, 0, 0);
        drive(1, 1, 4'h0, 4'hC, 0, 1);
        drive(0, 0, 0, 0, 0, 1);

        // Pointer wrap: six words streamed through channel 1
        for (int i = 0; i < 6; i++) drive(1, 0, 4'(i * 3 + 1), 4'h0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);

        // Integrity error is sticky; the word still lands in channel 1
        drive(1, 0, 4'h2, 4'h1, 0, 0);
        drive(1, 1, 4'h0, 4'h6, 0, 0);
        drive(0, 0, 4'hF, 4'hF, 1, 1);
        drive(0, 0, 0, 0, 1, 1);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // Reset mid-operation with both FIFOs full
        drive(1, 0, 4'h4, 4'h0, 0, 0);
        drive(1, 0, 4'h8, 4'h0, 0, 0);
        drive(1, 1, 4'h0, 4'hB, 0, 0);
        drive(1, 1, 4'h0, 4'hD, 0, 0);
        drive(1, 1, 4'h0, 4'hE, 0, 0);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        drive(1, 0, 4'h6, 4'h0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);

        // Random clean traffic, both channels popping independently
        for (int i = 0; i < 60; i++) begin
            logic              s;
            logic [DATA_W-1:0] d;
            s = 1'($urandom_range(0, 1));
            d = 4'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 1)), s, s ? 4'h0 : d, s ? d : 4'h0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drive(0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
